alu_op_sequencer: RTL and testbench

//  Issue controller for the integer execute stage. Accepts one R-type op (funct + operands) per handshake.

---
 rtl/alu_pkg.sv | 56 +++++
 rtl/muldiv_core.sv | 110 +++++++++++
 rtl/alu_op_sequencer.sv | 152 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the integer execute stage: R-type funct values,
// ALU function codes, issue-FSM states and the funct decoder.
package alu_pkg;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_NOP  = 6'b000000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_MULT = 3'b101;
  localparam logic [2:0] ALU_DIV  = 3'b110;
  localparam logic [2:0] ALU_NOP  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALU,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } seq_state_e;

  typedef struct packed {
    logic [2:0] code;
    logic       illegal;
  } decode_t;

  // Unlisted funct values decode to NOP with the illegal flag raised
  function automatic decode_t decode_funct(input logic [5:0] funct);
    decode_t d;
    d.code    = ALU_NOP;
    d.illegal = 1'b0;
    case (funct)
      FN_ADD:  d.code = ALU_ADD;
      FN_SUB:  d.code = ALU_SUB;
      FN_AND:  d.code = ALU_AND;
      FN_OR:   d.code = ALU_OR;
      FN_SLT:  d.code = ALU_SLT;
      FN_MULT: d.code = ALU_MULT;
      FN_DIV:  d.code = ALU_DIV;
      FN_NOP:  d.code = ALU_NOP;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Signed iterative multiply/divide engine: WIDTH shift-add or restoring
// steps on operand magnitudes, followed by a sign-fix cycle.
module muldiv_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    P_IDLE,
    P_RUN,
    P_FIX
  } phase_e;

  phase_e           r_phase;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_mb;
  logic [WIDTH:0]   r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH+1:0]   w_div_trial;
  logic               w_div_fits;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign w_mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;

  // done flags the final step, so the parent's FIX cycle coincides with
  // the cycle in which hi/lo below carry the sign-fixed result
  assign done = (r_phase == P_RUN) && (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_mul_sum   = r_hi + {1'b0, (r_lo[0] ? r_mb : '0)};
    w_div_shift = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    w_div_trial = {1'b0, w_div_shift} - {2'b00, r_mb};
    w_div_fits  = ~w_div_trial[WIDTH+1];
    w_prod      = {r_hi[WIDTH-1:0], r_lo};
    w_quot      = r_lo;
    w_rem       = r_hi[WIDTH-1:0];
    if (r_neg_q) begin
      w_prod = ~w_prod + 1'b1;
      w_quot = ~w_quot + 1'b1;
    end
    if (r_neg_r) begin
      w_rem = ~w_rem + 1'b1;
    end
    hi = r_is_div ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
    lo = r_is_div ? w_quot : w_prod[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase  <= P_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_mb     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (start) begin
      r_phase  <= P_RUN;
      r_cnt    <= '0;
      r_is_div <= is_div;
      r_neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
      r_neg_r  <= a[WIDTH-1];
      r_mb     <= w_mag_b;
      r_hi     <= '0;
      r_lo     <= w_mag_a;
    end else begin
      unique case (r_phase)
        P_RUN: begin
          if (r_is_div) begin
            r_hi <= w_div_fits ? w_div_trial[WIDTH:0] : w_div_shift;
            r_lo <= {r_lo[WIDTH-2:0], w_div_fits};
          end else begin
            r_hi <= {1'b0, w_mul_sum[WIDTH:1]};
            r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (done) begin
            r_phase <= P_FIX;
          end
        end
        P_FIX:   r_phase <= P_IDLE;
        default: r_phase <= P_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue controller for the integer execute stage: single-cycle ops go to the
// external ALU, MULT/DIV run on muldiv_core and write the HI/LO registers.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [2:0]       alu_f,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             illegal
);

  seq_state_e       r_state;
  seq_state_e       w_next;
  logic [2:0]       r_code;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dbz;
  logic             r_ill;

  decode_t          w_dec;
  logic             w_accept;
  logic             w_b_zero;
  logic             w_dbz;
  logic             w_core_start;
  logic             w_core_done;
  logic [WIDTH-1:0] w_core_hi;
  logic [WIDTH-1:0] w_core_lo;

  assign w_dec        = decode_funct(func);
  assign w_accept     = in_valid && (r_state == S_IDLE);
  assign w_b_zero     = (op_b == '0);
  assign w_dbz        = (w_dec.code == ALU_DIV) && w_b_zero;
  assign w_core_start = w_accept &&
                        ((w_dec.code == ALU_MULT) || ((w_dec.code == ALU_DIV) && !w_b_zero));

  muldiv_core #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_core_start),
    .is_div (w_dec.code == ALU_DIV),
    .a      (op_a),
    .b      (op_b),
    .done   (w_core_done),
    .hi     (w_core_hi),
    .lo     (w_core_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (w_dec.code)
            ALU_MULT: w_next = S_MUL;
            ALU_DIV:  w_next = w_b_zero ? S_DONE : S_DIV;
            ALU_NOP:  w_next = S_DONE;
            default:  w_next = S_ALU;
          endcase
        end
      end
      S_ALU:        w_next = S_DONE;
      S_MUL, S_DIV: if (w_core_done) w_next = S_FIX;
      S_FIX:        w_next = S_DONE;
      S_DONE:       if (out_ready) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    alu_f     = (r_state == S_ALU) ? r_code : ALU_NOP;
  end

  // Divide-by-zero writes HI/LO at accept since it bypasses the engine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code   <= ALU_NOP;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_result <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dbz    <= 1'b0;
      r_ill    <= 1'b0;
    end else if (w_accept) begin
      r_code   <= w_dec.code;
      r_alu_a  <= op_a;
      r_alu_b  <= op_b;
      r_result <= '0;
      r_ill    <= w_dec.illegal;
      r_dbz    <= w_dbz;
      if (w_dbz) begin
        r_hi <= op_a;
        r_lo <= '1;
      end
    end else begin
      unique case (r_state)
        S_ALU: r_result <= alu_result;
        S_FIX: begin
          r_hi <= w_core_hi;
          r_lo <= w_core_lo;
        end
        S_DONE: begin
          if (out_ready) begin
            r_dbz <= 1'b0;
            r_ill <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign result      = r_result;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;
  assign illegal     = r_ill;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed ops with hand-computed
// results, a behavioural ALU, and a monitor checking each completion.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  func = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [2:0]  alu_f;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;
  logic        illegal;

  alu_op_sequencer #(
    .WIDTH(32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .func        (func),
    .op_a        (op_a),
    .op_b        (op_b),
    .alu_f       (alu_f),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_f)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    int          lat;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int unsigned acc_cyc = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (txn %0d): got 0x%08h, expected 0x%08h", nm, id, act, exp);
    end
  endtask

  // Monitor: first cycle of out_valid pops and checks; later cycles check hold-stability
  initial begin : monitor
    exp_t cur;
    bit   have_cur;
    have_cur = 1'b0;
    cur = '{id: -1, lat: 0, res: '0, hi: '0, lo: '0, dbz: 1'b0, ill: 1'b0};
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (!have_cur) begin
          have_cur = 1'b1;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got out_valid=1, expected no pending op");
          end else begin
            cur = sb.pop_front();
            chk("latency", cur.id, 32'(cyc - acc_cyc + 1), 32'(cur.lat));
            chk("result", cur.id, result, cur.res);
            chk("hi", cur.id, hi, cur.hi);
            chk("lo", cur.id, lo, cur.lo);
            chk("div_by_zero", cur.id, 32'(div_by_zero), 32'(cur.dbz));
            chk("illegal", cur.id, 32'(illegal), 32'(cur.ill));
          end
        end else begin
          chk("held_result", cur.id, result, cur.res);
          chk("held_flags", cur.id, {30'd0, div_by_zero, illegal}, {30'd0, cur.dbz, cur.ill});
          chk("held_in_ready", cur.id, 32'(in_ready), 32'd0);
        end
      end else begin
        have_cur = 1'b0;
      end
    end
  end

  task automatic issue(input int id, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] res, input logic [31:0] ehi,
                       input logic [31:0] elo, input logic dbz, input logic ill, input int hold);
    exp_t e;
    int   n;
    int   busy;
    bit   seen;
    int   hold_left;
    e = '{id: id, lat: lat, res: res, hi: ehi, lo: elo, dbz: dbz, ill: ill};
    sb.push_back(e);
    @(negedge clk);
    func = f; op_a = a; op_b = b; in_valid = 1'b1;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout (txn %0d): in_ready=0 after %0d cycles, expected 1", id, n);
      in_valid = 1'b0;
      out_ready = 1'b1;
      return;
    end
    acc_cyc = cyc + 1;
    @(posedge clk);
    #1;
    // Scramble inputs after accept; the op must use the registered values
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom; func = 6'b100010;
    busy = 0; seen = 1'b0; hold_left = 0;
    while (busy < 200) begin
      @(negedge clk);
      if (in_ready) break;
      busy++;
      if (out_valid && !seen) begin
        seen = 1'b1;
        hold_left = hold;
      end else if (seen && hold_left > 0) begin
        hold_left--;
      end
      if (seen && hold_left == 0) out_ready = 1'b1;
    end
    chk("busy_cycles", id, 32'(busy), 32'(lat + hold));
    out_ready = 1'b1;
  endtask

  task automatic reset_mid_mult();
    int n;
    @(negedge clk);
    func = 6'b011000; op_a = 32'hFFFF_FFFD; op_b = 32'd4; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_accept", 100, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_busy_in_ready", 100, 32'(in_ready), 32'd0);
    chk("abort_lo_before", 100, lo, 32'd42);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 100, 32'(out_valid), 32'd0);
    chk("abort_in_ready", 100, 32'(in_ready), 32'd1);
    chk("abort_hi", 100, hi, 32'd0);
    chk("abort_lo", 100, lo, 32'd0);
    chk("abort_alu_f", 100, 32'(alu_f), 32'd7);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", 0, 32'(in_ready), 32'd1);
    chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
    chk("rst_alu_f", 0, 32'(alu_f), 32'd7);
    chk("rst_alu_a", 0, alu_a, 32'd0);
    chk("rst_alu_b", 0, alu_b, 32'd0);
    chk("rst_result", 0, result, 32'd0);
    chk("rst_hi", 0, hi, 32'd0);
    chk("rst_lo", 0, lo, 32'd0);
    chk("rst_flags", 0, {30'd0, div_by_zero, illegal}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //     id  funct      op_a          op_b          lat res           hi            lo            dbz  ill  hold
    issue(1,  6'b100000, 32'd5,        32'd7,        2,  32'd12,       32'd0,        32'd0,        1'b0,1'b0,0);
    issue(2,  6'b011000, 32'hFFFFFFFD, 32'd4,        34, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0,1'b0,0);
    issue(3,  6'b100010, 32'd5,        32'd7,        2,  32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0,1'b0,0);
    issue(4,  6'b011010, 32'd7,        32'hFFFFFFFE, 34, 32'd0,        32'd1,        32'hFFFFFFFD, 1'b0,1'b0,0);
    issue(5,  6'b011010, 32'h80000000, 32'hFFFFFFFF, 34, 32'd0,        32'd0,        32'h80000000, 1'b0,1'b0,0);
    issue(6,  6'b011010, 32'd9,        32'd0,        1,  32'd0,        32'd9,        32'hFFFFFFFF, 1'b1,1'b0,0);
    issue(7,  6'b100100, 32'hF0F01234, 32'h0FF0FF00, 2,  32'h00F01200, 32'd9,        32'hFFFFFFFF, 1'b0,1'b0,0);
    issue(8,  6'b100101, 32'hF0F01234, 32'h0FF0FF00, 2,  32'hFFF0FF34, 32'd9,        32'hFFFFFFFF, 1'b0,1'b0,0);
    issue(9,  6'b101010, 32'd3,        32'hFFFFFFFF, 2,  32'd0,        32'd9,        32'hFFFFFFFF, 1'b0,1'b0,5);
    issue(10, 6'b101010, 32'hFFFFFFFF, 32'd3,        2,  32'd1,        32'd9,        32'hFFFFFFFF, 1'b0,1'b0,0);
    issue(11, 6'b000000, 32'd1,        32'd2,        1,  32'd0,        32'd9,        32'hFFFFFFFF, 1'b0,1'b0,0);
    issue(12, 6'b111111, 32'd1,        32'd2,        1,  32'd0,        32'd9,        32'hFFFFFFFF, 1'b0,1'b1,0);
    issue(13, 6'b011000, 32'h80000000, 32'h80000000, 34, 32'd0,        32'h40000000, 32'd0,        1'b0,1'b0,0);
    issue(14, 6'b011010, 32'hFFFFFFF9, 32'd2,        34, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0,1'b0,0);
    issue(15, 6'b011000, 32'd7,        32'd6,        34, 32'd0,        32'd0,        32'd42,       1'b0,1'b0,0);
    reset_mid_mult();
    issue(16, 6'b100000, 32'd5,        32'd7,        2,  32'd12,       32'd0,        32'd0,        1'b0,1'b0,0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending ops, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
